priority_event_scheduler: RTL
=============================

# priority_event_scheduler

Parametrised, registered priority encoder that captures one-cycle request events into a sticky pending vector and presents them one at a time as an index on a valid/ready output. It supports fixed priority (highest index wins) and round-robin selection. It sits between interrupt/event sources and a single consumer that services one source per handshake. Unlike a bare encoder, it never drives Z; when no request is pending, it reports `out_valid`=0.

## Interface
- `N`, 8: number of request lines, ≥2.
- `IDX_W`, `$clog2(N)`: index width (derived, do not override).
- `RR`, 0: 0 = fixed priority (highest set index wins); 1 = round-robin.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_in` in N: request events, bit i high for one cycle = one event on source i.
- `out_ready` in 1: consumer accepts `out_idx` this cycle.
- `out_valid` out 1: `out_idx` holds a serviced source.
- `out_idx` out IDX_W: index of the source being presented.
- `pending` out N: registered pending vector, excludes the in-flight index.
- `overflow` out 1: one-cycle pulse when a request hits an already-pending bit.

## Operation
- `pending` bit i is set by `req_in[i]`. It is cleared only when index i is loaded into the output register.
- Load condition: `load` = `!out_valid || out_ready`. On `load`:
  - If `pending != 0`: `out_valid`←1, `out_idx`←selected index, and that pending bit is cleared.
  - Otherwise: `out_valid`←0, and `out_idx` holds its last value.
- Selection uses the registered `pending` only, never the same-cycle `req_in`.
- Fixed mode: select the highest set index of `pending`.
- RR mode:
  - `rr_ptr` (IDX_W bits) holds the last loaded index.
  - Search order is `rr_ptr`-1, `rr_ptr`-2, … down to 0, then wrap to N-1 … `rr_ptr`.
  - `rr_ptr` updates only on a load with valid selection.
  - The pointer is unused in fixed mode.
- Simultaneous set and clear on the same bit: `req_in[i]` and a load of index i in the same cycle leave `pending[i]`=1. The new event wins, and `overflow` does not fire.
- `overflow`: registered pulse, asserted the cycle after `req_in[i]`=1 while `pending[i]`=1 and bit i is not being loaded. The events merge; no count is kept.
- A request for the index currently in flight (`out_valid`=1, `out_idx`=i, not yet accepted) sets `pending[i]` normally. It is not an overflow.
- `out_idx`/`out_valid` are stable while `out_valid`=1 and `out_ready`=0. The consumer may hold `out_ready` high continuously.

## Timing
- Reset values: `pending`=0, `out_valid`=0, `out_idx`=0, `overflow`=0, `rr_ptr`=0.
  - With `rr_ptr`=0, the first RR search starts at N-1, identical to fixed priority.
- Reset asserted mid-operation clears everything immediately (asynchronous). Events in flight are lost.
- Latency: `req_in` at edge t → `pending` at t+1 → `out_valid` at t+2 when the output is empty.
- Throughput: one index per cycle with `out_ready` held high and multiple bits pending.
- All outputs are registered. There is no combinational path from `req_in` or `out_ready` to any output.

## Structure
- Shared package `prio_pkg`: function `clog2_safe`, and the RR mode constants `PRIO_FIXED`=0 and `PRIO_RR`=1.
- Sub-module `prio_find_msb` (parameter N): combinational highest-set-bit finder producing `found` and `idx`.
  - Fixed mode uses one instance.
  - RR mode uses two instances, on `pending` masked to bits below `rr_ptr` and on unmasked `pending`. It takes the masked result if found, else the unmasked result.
- Top level holds `pending`, the output register, `rr_ptr` and `overflow`.

## Test plan
- Reset check: assert `rst_n`=0 mid-stream with `pending`=8'hA5 → all outputs 0 at once; after release, `out_valid` stays 0 until a new request arrives.
- Fixed priority (N=8, RR=0): pulse `req_in`=8'b0010_0110, `out_ready`=1 → `out_valid` at t+2, and `out_idx` sequence 5, 2, 1 on consecutive cycles. Then `out_valid`=0.
- Backpressure: fixed mode, `req_in`=8'h81, `out_ready`=0 for 5 cycles → `out_idx`=7 held stable with `pending`=8'h01. When `out_ready` rises, `out_idx`=0 follows the next cycle.
- Round-robin (RR=1): hold `req_in`=8'b1000_1001 every cycle with `out_ready`=1 → steady-state sequence 7, 3, 0, 7, 3, 0. No source is starved. `overflow` pulses for bits already pending.
- Simultaneous set/clear: re-request bit 4 in the same cycle it loads → `pending[4]`=1 afterwards, `overflow`=0, and index 4 is presented again.
- Overflow: two `req_in[2]` pulses two cycles apart, with `out_ready`=0 and `out_valid` occupied by index 6 → one `overflow` pulse; index 2 is presented exactly once later.

Source files
------------

// File: rtl/prio_pkg.sv
// Shared constants and helpers for the priority event scheduler.
package prio_pkg;

    // Selection modes for the RR parameter
    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    // Index width for n entries, never less than one bit
    function automatic int clog2_safe(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_find_msb.sv
// Combinational highest-set-bit finder.
module prio_find_msb
    import prio_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = clog2_safe(N)
) (
    input  logic [N-1:0]     vec,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan upwards so the last (highest) set bit wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/priority_event_scheduler.sv
// Sticky event capture with fixed-priority or round-robin presentation
// of one pending source index at a time on a registered valid/ready port.
//
// Handshake: out_valid/out_idx are registers. An index is transferred on a
// rising edge where out_valid && out_ready. While out_valid=1 and
// out_ready=0 both out_valid and out_idx hold. The output register reloads
// whenever it is empty or being accepted (load = !out_valid || out_ready),
// so back-to-back transfers occur with out_ready held high.
module priority_event_scheduler
    import prio_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = clog2_safe(N),
    parameter int RR    = PRIO_FIXED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending,
    output logic             overflow
);

    logic             load;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [N-1:0]     clr_mask;

    assign load = !out_valid || out_ready;

    if (RR == PRIO_RR) begin : g_rr
        logic [IDX_W-1:0] rr_ptr;
        logic [N-1:0]     below_mask;
        logic             low_found;
        logic [IDX_W-1:0] low_idx;
        logic             all_found;
        logic [IDX_W-1:0] all_idx;

        // Bits strictly below the last served index are searched first
        always_comb begin
            below_mask = '0;
            for (int i = 0; i < N; i++) begin
                below_mask[i] = (IDX_W'(i) < rr_ptr);
            end
        end

        prio_find_msb #(.N(N), .IDX_W(IDX_W)) u_low (
            .vec   (pending & below_mask),
            .found (low_found),
            .idx   (low_idx)
        );

        prio_find_msb #(.N(N), .IDX_W(IDX_W)) u_all (
            .vec   (pending),
            .found (all_found),
            .idx   (all_idx)
        );

        assign sel_found = low_found || all_found;
        assign sel_idx   = low_found ? low_idx : all_idx;

        // Remember the last loaded index as the rotation point
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rr_ptr <= '0;
            end else if (load && sel_found) begin
                rr_ptr <= sel_idx;
            end
        end
    end else begin : g_fixed
        prio_find_msb #(.N(N), .IDX_W(IDX_W)) u_msb (
            .vec   (pending),
            .found (sel_found),
            .idx   (sel_idx)
        );
    end

    // One-hot of the index leaving pending this cycle
    always_comb begin
        clr_mask = '0;
        if (load && sel_found) clr_mask[sel_idx] = 1'b1;
    end

    // Pending capture: new events win over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= (pending & ~clr_mask) | req_in;
            overflow <= |(req_in & pending & ~clr_mask);
        end
    end

    // Output register: refill on load, hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else if (load) begin
            if (sel_found) begin
                out_valid <= 1'b1;
                out_idx   <= sel_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
